dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory of the single-cycle CPU between two requesters.
- Port 0 is the CPU load/store path; port 1 is the debug/DMA loader.
- Port 0 has fixed priority; a starvation counter guarantees port 1 progress.
- Sits between the CPU datapath in top and the data memory instance; a low m0_gnt stalls the CPU for that cycle.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
STARVE_LIMIT, 4, consecutive cycles port 1 may be refused before it is forced ahead of port 0 (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
m0_req  input  1  port 0 access request; held with all m0 fields stable until granted
m0_we  input  1  port 0 write enable (1 = write, 0 = read)
m0_addr  input  AW  port 0 address
m0_wdata  input  DW  port 0 write data
m0_gnt  output  1  port 0 request accepted this cycle
m0_rvalid  output  1  port 0 read data valid
m0_rdata  output  DW  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings as the port 0 signals, for port 1
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid one cycle after a read strobe

Behaviour:
- While rst = 0: starve_cnt = 0, rvalid regs = 0, owner reg = 0.
- While rst = 0: m0_gnt, m1_gnt, mem_en and mem_we are forced to 0; m0_rvalid and m1_rvalid are 0; rdata outputs are 0.
- Arbitration is combinational, same cycle, at most one grant per cycle:
  - force1 = (starve_cnt >= STARVE_LIMIT).
  - m1_req && force1 -> grant port 1.
  - Otherwise m0_req -> grant port 0.
  - Otherwise m1_req -> grant port 1.
  - Otherwise no grant.
- Granted port drives mem_addr, mem_wdata and mem_we, and mem_en = 1.
- With no grant: mem_en = 0, mem_we = 0, mem_addr and mem_wdata = 0.
- starve_cnt is updated on every clk edge:
  - Cleared when m1 is granted or m1_req = 0.
  - Incremented by 1 when m1_req = 1 and m1 is not granted.
  - Saturates at 255.
- Read return:
  - A granted read (we = 0) sets that port's rvalid register for exactly the next cycle.
  - The owner reg records which port performed the read.
  - m0_rdata = mem_rdata when m0_rvalid = 1, else 0. Same rule for port 1.
  - A granted write produces no rvalid.
- Back-to-back reads by alternating ports are allowed: each port's rvalid follows its own grant by one cycle.
- Read data is never misrouted.
- A request held across refusal keeps its address and data; the arbiter does not latch request fields.
- Reset asserted mid-access:
  - Any pending rvalid is dropped (0) immediately; no late return occurs after reset release.
  - starve_cnt restarts from 0.
- Simultaneous requests when starve_cnt = STARVE_LIMIT - 1:
  - Port 0 wins this cycle and starve_cnt becomes STARVE_LIMIT.
  - Port 1 wins the next cycle even if m0_req = 1.
- After a forced port-1 grant, port 0 regains priority on the following cycle.

Test Plan:
- Reset hold: rst = 0 with m0_req = 1, m1_req = 1 -> both gnt = 0, mem_en = 0, rvalid = 0. After rst = 1, m0_gnt = 1 in the first cycle.
- Port 0 write then read: write addr 0x10 data 0xDEADBEEF, next cycle read 0x10 -> mem_we = 1 on the write cycle; the read cycle has mem_en = 1, mem_we = 0; m0_rvalid = 1 one cycle later with m0_rdata = 0xDEADBEEF; m1_rvalid stays 0.
- Starvation: m0_req and m1_req held at 1, STARVE_LIMIT = 4 -> m0_gnt for 4 cycles, m1_gnt on cycle 5, m0_gnt again on cycle 6, starve_cnt = 0 after cycle 5.
- Alternating reads: m1 alone reads 0x20 (mem = 0x11), next cycle m0 alone reads 0x24 (mem = 0x22) -> m1_rvalid with 0x11, then m0_rvalid with 0x22, one cycle apart, no overlap.
- Idle port 1: m1_req toggles 1 for 3 refused cycles then drops to 0 -> starve_cnt = 3, then 0; no m1_gnt issued.
- Reset mid-read: grant m0 read, assert rst = 0 on the following cycle -> m0_rvalid = 0 throughout reset, and no rvalid appears after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data memory (port 0 = CPU, port 1 = debug/DMA).
// Latency: grant and memory strobe in the request cycle; read data returns with rvalid one cycle later.
// Backpressure: a refused port sees gnt=0 and must hold its request; port 1 is forced ahead after STARVE_LIMIT refusals.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter is 8 bits wide; it saturates at 255, which covers the full legal limit range.
    localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    logic [7:0] starve_cnt;
    logic       rvalid0_q;
    logic       rvalid1_q;
    logic       owner_q;     // 0: pending read belongs to port 0, 1: to port 1
    logic       force1;
    logic       gnt0;
    logic       gnt1;

    // Grant decision: a starved port 1 goes first, otherwise port 0 has fixed priority.
    // Everything is gated by reset so no access can leak out while rst is low.
    always_comb begin
        force1 = (starve_cnt >= LIMIT);
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (rst) begin
            if (m1_req && force1) begin
                gnt1 = 1'b1;
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Memory-side mux: the granted port's fields pass straight through; idle drives zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_en    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Starvation counter: counts consecutive cycles port 1 asked and was refused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (gnt1 || !m1_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Read-return tracking: a granted read flags its own port for exactly the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 && !m0_we;
            rvalid1_q <= gnt1 && !m1_we;
            if ((gnt0 && !m0_we) || (gnt1 && !m1_we)) begin
                owner_q <= gnt1;
            end
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;

    // Registers are already cleared by the async reset; the extra gating keeps the
    // outputs at zero for the whole time reset is held.
    assign m0_rvalid = rst && rvalid0_q && !owner_q;
    assign m1_rvalid = rst && rvalid1_q &&  owner_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic with random resets.
// A reference model predicts grants and read data; a separate monitor pops the scoreboard on rvalid.
// Requesters hold their request until granted, as the CPU and loader do.
module tb_dmem_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int STARVE_LIMIT = 4;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem     [64];   // memory behind the DUT, written only from mem_* outputs
    logic [31:0] ref_mem [64];   // model's view, written only from requester intent

    int   starve;                // model: consecutive refused cycles of port 1
    logic exp_g0, exp_g1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory; returns noise when not read so rdata gating is exercised.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[5:0]];
        else                   mem_rdata <= $urandom;
        if (mem_en && mem_we)  mem[mem_addr[5:0]] <= mem_wdata;
    end

    // Reference model: predicts this cycle's grant, checks the memory side, feeds the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            exp_g0 = 1'b0;
            exp_g1 = 1'b0;
            starve = 0;
            check("rst_gnt_en_we", {60'd0, m0_gnt, m1_gnt, mem_en, mem_we}, 64'd0);
        end else begin
            exp_g1 = m1_req && ((starve >= STARVE_LIMIT) || !m0_req);
            exp_g0 = m0_req && !exp_g1;
            check("gnt", {62'd0, m0_gnt, m1_gnt}, {62'd0, exp_g0, exp_g1});
            check("mem_en", {63'd0, mem_en}, {63'd0, exp_g0 | exp_g1});
            if (exp_g0 || exp_g1) begin
                logic          we;
                logic [AW-1:0] a;
                logic [DW-1:0] wd;
                exp_t          e;
                we = exp_g0 ? m0_we    : m1_we;
                a  = exp_g0 ? m0_addr  : m1_addr;
                wd = exp_g0 ? m0_wdata : m1_wdata;
                check("mem_we", {63'd0, mem_we}, {63'd0, we});
                check("mem_addr", {32'd0, mem_addr}, {32'd0, a});
                check("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
                if (we) begin
                    ref_mem[a[5:0]] = wd;
                end else begin
                    e.port = exp_g0 ? 0 : 1;
                    e.data = ref_mem[a[5:0]];
                    e.due  = cyc + 1;
                    sbq.push_back(e);
                end
            end else begin
                check("idle_mem", {mem_we, 31'd0, mem_addr}, 64'd0);
                check("idle_wdata", {32'd0, mem_wdata}, 64'd0);
            end
            starve = (exp_g1 || !m1_req) ? 0 : starve + 1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            check("rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
            check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        end else begin
            if (m0_rvalid && m1_rvalid) begin
                check("rvalid_overlap", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
            end else if (m0_rvalid || m1_rvalid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rd_port", {63'd0, m1_rvalid}, 64'(e.port));
                    check("rd_due", 64'(cyc), 64'(e.due));
                    check("rd_data", {32'd0, (m1_rvalid ? m1_rdata : m0_rdata)}, {32'd0, e.data});
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                check("missing_rvalid", 64'd0, 64'(sbq[0].port + 1));
                void'(sbq.pop_front());
            end
            if (!m0_rvalid) check("m0_rdata_idle", {32'd0, m0_rdata}, 64'd0);
            if (!m1_rvalid) check("m1_rdata_idle", {32'd0, m1_rdata}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[32] = 32'h11; ref_mem[32] = 32'h11;
        mem[36] = 32'h22; ref_mem[36] = 32'h22;
        mem_rdata = '0;
        starve = 0;
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;

        // Reset hold with both ports requesting.
        rst = 1'b0;
        drive0(1'b1, 1'b0, 32'h4, 32'h0);
        drive1(1'b1, 1'b0, 32'h8, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("hold_gnt", {62'd0, m0_gnt, m1_gnt}, 64'd0);
            check("hold_mem_en", {63'd0, mem_en}, 64'd0);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        check("release_m0_gnt", {63'd0, m0_gnt}, 64'd1);
        tick();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // Port 0 write then read back.
        drive0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_mem_we", {62'd0, mem_en, mem_we}, 64'd3);
        tick();
        drive0(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("rd_mem_en_we", {62'd0, mem_en, mem_we}, 64'd2);
        tick();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("wr_rd_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd2);
        check("wr_rd_rdata", {32'd0, m0_rdata}, 64'hDEADBEEF);
        tick();

        // Starvation: both held, port 1 forced on the fifth cycle only.
        drive1(1'b1, 1'b0, 32'h30, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            drive0(1'b1, 1'b1, 32'(i), 32'(i * 3));
            if (i == 6) drive1(1'b1, 1'b1, 32'h31, 32'h77);
            @(negedge clk);
            check("starve_gnt", {62'd0, m0_gnt, m1_gnt}, (i == 5) ? 64'd1 : 64'd2);
            tick();
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Alternating single-port reads.
        drive1(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("alt_m1_gnt", {63'd0, m1_gnt}, 64'd1);
        tick();
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        drive0(1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        check("alt_m1_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd1);
        check("alt_m1_rdata", {32'd0, m1_rdata}, 64'h11);
        tick();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("alt_m0_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd2);
        check("alt_m0_rdata", {32'd0, m0_rdata}, 64'h22);
        tick();

        // Port 1 refused three times then withdraws; the count must restart.
        drive1(1'b1, 1'b1, 32'h3A, 32'h55);
        for (int i = 0; i < 9; i++) begin
            drive0(1'b1, 1'b1, 32'(8 + i), 32'(i));
            if (i == 3) drive1(1'b0, 1'b1, 32'h3A, 32'h55);
            if (i == 4) drive1(1'b1, 1'b1, 32'h3A, 32'h55);
            @(negedge clk);
            check("idle1_m1_gnt", {63'd0, m1_gnt}, (i == 8) ? 64'd1 : 64'd0);
            tick();
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset asserted right after a granted read.
        drive0(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("midrd_gnt", {63'd0, m0_gnt}, 64'd1);
        tick();
        rst = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("midrd_rvalid_rst", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
            tick();
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrd_rvalid_after", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
            tick();
        end

        // Randomized traffic; each requester holds until the model says it was granted.
        for (int i = 0; i < 2000; i++) begin
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            if (!(m0_req && !exp_g0)) begin
                drive0(($urandom_range(0, 99) < 60), $urandom_range(0, 1),
                       32'($urandom_range(0, 63)), $urandom);
            end
            if (!(m1_req && !exp_g1)) begin
                drive1(($urandom_range(0, 99) < 40), $urandom_range(0, 1),
                       32'($urandom_range(0, 63)), $urandom);
            end
            tick();
        end
        rst = 1'b1;
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
